// File: rtl/credit_rr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ burst-capable requesters into one
// ready-less downstream write port. Grants are held for a whole burst, and a
// credit counter mirrors free downstream entries so the consumer never overflows.
module credit_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int CREDITS = 3,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [IDW-1:0]           out_id,
    input  logic                     credit_return,
    output logic [CW-1:0]            credits,
    output logic                     busy,
    output logic                     error_credit
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [CW-1:0]  CREDITS_V = CW'(CREDITS);
    localparam logic [IDW:0]   NR_V      = (IDW + 1)'(NUM_REQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]   out_id_q, out_id_d;
    logic             err_q, err_d;

    logic             can_issue;
    logic             found;
    logic [IDW-1:0]   winner;
    logic [IDW:0]     idx;
    logic [IDW-1:0]   sel;
    logic [IDW:0]     sel_inc;
    logic             accept;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    // Round-robin search for the first valid requester starting at ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (idx >= NR_V) idx = idx - NR_V;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    // Grant selection, handshake and beat mux; ready never looks at req_data.
    always_comb begin
        can_issue = (credits_q != '0) || credit_return;
        sel       = (state_q == LOCKED) ? owner_q : winner;
        req_ready = '0;
        if (can_issue && ((state_q == LOCKED) || found)) req_ready[sel] = 1'b1;
        accept    = req_valid[sel] && req_ready[sel];
        sel_last  = req_last[sel];
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
        end
        sel_inc = {1'b0, sel} + 1'b1;
        if (sel_inc >= NR_V) sel_inc = '0;
    end

    // Next-state for lock FSM, rotation pointer, output beat and credits.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        credits_d   = credits_q;
        err_d       = err_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_id_d    = sel;
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = sel_inc[IDW-1:0];
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = sel;
            end
        end

        // A return with nothing outstanding is a protocol error; clamp and flag it.
        if (accept && !credit_return) begin
            credits_d = credits_q - 1'b1;
        end else if (!accept && credit_return) begin
            if (credits_q == CREDITS_V) err_d = 1'b1;
            else                        credits_d = credits_q + 1'b1;
        end
    end

    // State registers; reset drops any burst in flight and refills credits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            credits_q   <= CREDITS_V;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            credits_q   <= credits_d;
            err_q       <= err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_id       = out_id_q;
    assign credits      = credits_q;
    assign busy         = (state_q == LOCKED);
    assign error_credit = err_q;

endmodule

// File: tb/tb_credit_rr_arbiter.sv
// Directed bench for credit_rr_arbiter (NUM_REQ=4, WIDTH=32, CREDITS=3).
module tb_credit_rr_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
    logic         credit_return;
    logic [1:0]   credits;
    logic         busy;
    logic         error_credit;

    int passed = 0;
    int total  = 0;

    credit_rr_arbiter #(.NUM_REQ(4), .WIDTH(32), .CREDITS(3)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .credit_return(credit_return), .credits(credits),
        .busy(busy), .error_credit(error_credit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; credit_return = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_credits", credits, 3);
        chk("rst_busy", busy, 0);
        chk("rst_err", error_credit, 0);
        reset = 1'b0;

        // Round robin with single-beat bursts, credit returned every cycle.
        req_valid = 4'b1111; req_last = 4'b1111; credit_return = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + 32'(i));
        #1 chk("rr_ready0", req_ready, 4'b0001);
        tick(); chk("rr_v0", out_valid, 1); chk("rr_id0", out_id, 0); chk("rr_d0", out_data, 32'hA0);
        tick(); chk("rr_v1", out_valid, 1); chk("rr_id1", out_id, 1); chk("rr_d1", out_data, 32'hA1);
        tick(); chk("rr_v2", out_valid, 1); chk("rr_id2", out_id, 2); chk("rr_d2", out_data, 32'hA2);
        tick(); chk("rr_v3", out_valid, 1); chk("rr_id3", out_id, 3); chk("rr_d3", out_data, 32'hA3);
        tick(); chk("rr_v4", out_valid, 1); chk("rr_id4", out_id, 0); chk("rr_cr", credits, 3);
        req_valid = '0; credit_return = 1'b0;
        tick(); chk("rr_idle_v", out_valid, 0); chk("rr_idle_cr", credits, 3);

        // Burst from requester 2 (pointer now at 1) with requester 0 waiting.
        req_valid = 4'b0101; req_last = 4'b0000; credit_return = 1'b1;
        set_data(0, 32'hD0); set_data(2, 32'hAAAA);
        #1 chk("bu_ready_a", req_ready, 4'b0100);
        tick(); chk("bu_id_a", out_id, 2); chk("bu_d_a", out_data, 32'hAAAA); chk("bu_busy_a", busy, 1);
        set_data(2, 32'hBBBB);
        #1 chk("bu_ready_b", req_ready, 4'b0100);
        tick(); chk("bu_id_b", out_id, 2); chk("bu_d_b", out_data, 32'hBBBB); chk("bu_busy_b", busy, 1);
        set_data(2, 32'hCCCC); req_last = 4'b0100;
        tick(); chk("bu_id_c", out_id, 2); chk("bu_d_c", out_data, 32'hCCCC); chk("bu_busy_c", busy, 0);
        req_valid = 4'b0001; req_last = 4'b0001;
        #1 chk("bu_ready_d", req_ready, 4'b0001);
        tick(); chk("bu_id_d", out_id, 0); chk("bu_d_d", out_data, 32'hD0); chk("bu_cr", credits, 3);
        req_valid = '0; credit_return = 1'b0;
        tick(); chk("bu_idle_v", out_valid, 0);

        // Credit exhaustion with requester 1 streaming single beats.
        req_valid = 4'b0010; req_last = 4'b0010;
        set_data(1, 32'h101);
        tick(); chk("cx_cr1", credits, 2); chk("cx_d1", out_data, 32'h101);
        set_data(1, 32'h102);
        tick(); chk("cx_cr2", credits, 1);
        set_data(1, 32'h103);
        tick(); chk("cx_cr3", credits, 0); chk("cx_d3", out_data, 32'h103);
        set_data(1, 32'h104);
        #1 chk("cx_ready_blk", req_ready, 4'b0000);
        tick(); chk("cx_v_blk", out_valid, 0); chk("cx_cr_blk", credits, 0);
        credit_return = 1'b1;
        #1 chk("cx_ready_ret", req_ready, 4'b0010);
        tick(); chk("cx_v_ret", out_valid, 1); chk("cx_d_ret", out_data, 32'h104); chk("cx_cr_ret", credits, 0);
        credit_return = 1'b0; set_data(1, 32'h105);
        #1 chk("cx_ready_blk2", req_ready, 4'b0000);
        tick(); chk("cx_v_blk2", out_valid, 0);
        req_valid = '0; credit_return = 1'b1;
        tick(); tick(); tick();
        chk("cx_refill", credits, 3); chk("cx_err", error_credit, 0);
        credit_return = 1'b0;

        // Simultaneous issue and return at credits=2.
        req_valid = 4'b1000; req_last = 4'b1000; set_data(3, 32'h333);
        tick(); chk("sim_cr_a", credits, 2); chk("sim_d_a", out_data, 32'h333);
        set_data(3, 32'h334); credit_return = 1'b1;
        tick(); chk("sim_cr_b", credits, 2); chk("sim_d_b", out_data, 32'h334); chk("sim_id_b", out_id, 3);
        req_valid = '0;
        tick(); chk("sim_cr_c", credits, 3); chk("sim_err", error_credit, 0);
        credit_return = 1'b0;

        // Reset asserted on the second beat of a burst.
        req_valid = 4'b0010; req_last = 4'b0000; set_data(1, 32'hB1);
        tick(); chk("mr_busy1", busy, 1); chk("mr_cr1", credits, 2);
        set_data(1, 32'hB2); reset = 1'b1;
        tick(); chk("mr_v", out_valid, 0); chk("mr_busy", busy, 0); chk("mr_cr", credits, 3);
        chk("mr_id", out_id, 0); chk("mr_data", out_data, 0);
        reset = 1'b0; req_valid = 4'b1111; req_last = 4'b1111;
        #1 chk("mr_ptr0", req_ready, 4'b0001);
        req_valid = '0;

        // Spurious return with a full counter sets the sticky error.
        credit_return = 1'b1;
        tick(); chk("er_cr", credits, 3); chk("er_set", error_credit, 1);
        credit_return = 1'b0;
        tick(); tick(); chk("er_sticky", error_credit, 1); chk("er_cr2", credits, 3);
        reset = 1'b1;
        tick(); chk("er_clr", error_credit, 0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/credit_rr_arbiter.md
# credit_rr_arbiter

Merges up to NUM_REQ request streams into the single write port of a downstream `skid_buffer`, which has no ready signal and a fixed capacity. The block grants requesters in round-robin order and holds a grant across multi-beat bursts. It tracks free downstream entries with a credit counter so that the buffer can never overflow. It sits between producer ports (e.g. cache/bus masters) and a shared consumer.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, data width per beat
- CREDITS, 3, downstream entries available after reset (matches skid buffer depth)
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  beat is final beat of burst
- req_data  in  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  combinational; beat of requester i accepted when req_valid[i] && req_ready[i]
- out_valid  out  1  registered; drives skid buffer in_valid
- out_data  out  WIDTH  registered beat data
- out_id  out  clog2(NUM_REQ)  registered source index of out_data
- credit_return  in  1  one-cycle pulse per entry popped downstream (skid out_valid && out_ready)
- credits  out  clog2(CREDITS+1)  registered free-entry count
- busy  out  1  high while in LOCKED state
- error_credit  out  1  sticky; set on credit_return with credits == CREDITS and no issue

## Operation
- States: IDLE (no owner), LOCKED (owner holds grant until its last beat).
- can_issue = (credits != 0) || credit_return.
- IDLE: winner = first i with req_valid[i], searching ptr, ptr+1, … modulo NUM_REQ. req_ready[winner] = can_issue. All other bits are 0.
- LOCKED: req_ready[owner] = can_issue. All other bits are 0, even when valid.
- On accept with req_last=0 in IDLE: go to LOCKED, owner = winner.
- On accept with req_last=1 (either state): go to IDLE, ptr = (source+1) mod NUM_REQ.
- LOCKED with no owner valid: stay LOCKED, output idle (no preemption).
- Credits next = credits − issue + credit_return, where issue = accept this cycle.
- Simultaneous issue and return leaves credits unchanged.
- Return when credits == CREDITS and issue = 0: credits stays CREDITS and error_credit is set.
- credits never exceeds CREDITS and never underflows. Issue requires can_issue.
- Reset values: state IDLE, ptr 0, owner 0, out_valid 0, out_data 0, out_id 0, credits CREDITS, busy 0, error_credit 0.
- Reset mid-burst: the burst is dropped, the lock is released, and credits return to CREDITS. The downstream skid buffer must be reset in the same cycle.

## Timing
- A beat accepted in cycle N appears as out_valid=1, with out_data/out_id, in cycle N+1 for exactly one cycle.
- Peak throughput: 1 beat/cycle while credits allow.
- With credits=0, a credit_return in cycle N permits an accept in cycle N (no bubble).
- req_ready depends combinationally on req_valid, state, ptr, credits and credit_return. It has no dependence on req_data.
- busy rises the cycle after the first non-last beat is accepted. It falls the cycle after the last beat is accepted.
- credits reflects issues and returns from the previous cycle.

## Test plan
- Reset, then hold req_valid=4'b1111 with all req_last=1 and credit_return pulsed every cycle. Required: out_id sequence 0,1,2,3,0 and out_valid continuously high from the 2nd cycle on.
- Requester 2 sends a 3-beat burst (data A,B,C, last on C) while requester 0 is valid throughout. Required: out_id 2,2,2 with data A,B,C, then requester 0. busy is high for 2 cycles.
- No credit_return, with requester 1 streaming. Required: exactly 3 beats accepted, then req_ready=0 and credits=0. One credit_return pulse allows exactly one further accept in that same cycle.
- Issue and credit_return in the same cycle with credits=2. Required: credits stays 2 and data order is preserved.
- credit_return pulse right after reset (credits=3, no issue). Required: credits stays 3 and error_credit=1 until reset.
- Assert reset during the 2nd beat of a burst. Required: next cycle state IDLE, busy=0, out_valid=0, credits=3, ptr=0.
